// File: rtl/step_motor_pkg.sv
// Shared 3-phase step-motor definitions: drive patterns, ring index, decoder FSM states.
// Used by both the motor driver and the receive-side phase decoder.
package step_motor_pkg;

  // Drive patterns as {a, b, c}
  localparam logic [2:0] PAT_A    = 3'b100;
  localparam logic [2:0] PAT_AB   = 3'b110;
  localparam logic [2:0] PAT_B    = 3'b010;
  localparam logic [2:0] PAT_BC   = 3'b011;
  localparam logic [2:0] PAT_C    = 3'b001;
  localparam logic [2:0] PAT_CA   = 3'b101;
  localparam logic [2:0] PAT_NONE = 3'b000;
  localparam logic [2:0] PAT_ILL  = 3'b111;

  typedef logic [2:0] ring_idx_t;

  localparam ring_idx_t IDX_NONE = 3'd6;
  localparam ring_idx_t IDX_ILL  = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StTrack,
    StFault
  } step_state_e;

  function automatic ring_idx_t pat_to_idx(input logic [2:0] pat);
    ring_idx_t idx;
    case (pat)
      PAT_A:   idx = 3'd0;
      PAT_AB:  idx = 3'd1;
      PAT_B:   idx = 3'd2;
      PAT_BC:  idx = 3'd3;
      PAT_C:   idx = 3'd4;
      PAT_CA:  idx = 3'd5;
      PAT_NONE: idx = IDX_NONE;
      default: idx = IDX_ILL;
    endcase
    return idx;
  endfunction

  // (new - old) mod 6 for two valid ring indices
  function automatic logic [2:0] ring_delta(input ring_idx_t new_idx, input ring_idx_t old_idx);
    logic [3:0] diff;
    diff = {1'b0, new_idx} + 4'd6 - {1'b0, old_idx};
    if (diff >= 4'd6) diff = diff - 4'd6;
    return diff[2:0];
  endfunction

endpackage

// File: rtl/step_input_filter.sv
// Two-flop synchroniser plus stability counter for the {a,b,c} drive lines.
// Emits a one-cycle accept strobe when a new pattern has been stable for FILTER_LEN samples.
module step_input_filter #(
  parameter int unsigned FILTER_LEN = 2
) (
  input  logic       clk,
  input  logic       cr,
  input  logic [2:0] i_abc,
  output logic [2:0] o_pat,
  output logic       o_accept
);

  localparam logic [3:0] LenCnt = 4'(FILTER_LEN);

  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [3:0] r_cnt;
  logic [2:0] r_last;
  logic       w_accept;

  // Counter tracks the run length of r_sync2; comparing against r_sync1 lets it
  // update on the same edge that the new value lands in r_sync2.
  always_ff @(posedge clk) begin
    if (cr) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
      r_cnt   <= 4'd0;
      r_last  <= 3'b000;
    end else begin
      r_sync1 <= i_abc;
      r_sync2 <= r_sync1;
      if (r_sync1 != r_sync2) begin
        r_cnt <= 4'd1;
      end else if (r_cnt != LenCnt) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (w_accept) begin
        r_last <= r_sync2;
      end
    end
  end

  assign w_accept = (r_cnt == LenCnt) && (r_sync2 != r_last);
  assign o_accept = w_accept;
  assign o_pat    = r_sync2;

endmodule

// File: rtl/step_phase_decoder.sv
// Receive-side 3-phase step decoder: ring position tracking, step pulses, sticky fault.
// Optional stall detector enabled by defining STEP_STALL_DET_EN.
module step_phase_decoder
  import step_motor_pkg::*;
#(
  parameter int unsigned POS_W        = 16,
  parameter int unsigned FILTER_LEN   = 2
`ifdef STEP_STALL_DET_EN
  ,
  parameter int unsigned STALL_CYCLES = 1000
`endif
) (
  input  logic                    clk,
  input  logic                    cr,
  input  logic                    a,
  input  logic                    b,
  input  logic                    c,
  input  logic                    fault_clr,
  output logic                    step,
  output logic                    dir,
  output logic                    half,
  output logic signed [POS_W-1:0] pos,
  output logic                    fault,
  output logic                    tracking
`ifdef STEP_STALL_DET_EN
  ,
  output logic                    stall
`endif
);

  logic [2:0]        w_pat;
  logic              w_accept;
  ring_idx_t         w_new_idx;
  logic [2:0]        w_delta;

  step_state_e       r_state;
  step_state_e       w_state_nxt;
  ring_idx_t         r_old_idx;
  ring_idx_t         w_old_idx_nxt;
  logic [POS_W-1:0]  r_pos;
  logic [POS_W-1:0]  w_pos_nxt;
  logic              r_step;
  logic              w_step_nxt;
  logic              r_dir;
  logic              w_dir_nxt;
  logic              r_half;
  logic              w_half_nxt;
  logic signed [2:0] w_amt;

  step_input_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk      (clk),
    .cr       (cr),
    .i_abc    ({a, b, c}),
    .o_pat    (w_pat),
    .o_accept (w_accept)
  );

  assign w_new_idx = pat_to_idx(w_pat);
  assign w_delta   = ring_delta(w_new_idx, r_old_idx);

  always_comb begin
    w_state_nxt   = r_state;
    w_old_idx_nxt = r_old_idx;
    w_step_nxt    = 1'b0;
    w_dir_nxt     = r_dir;
    w_half_nxt    = r_half;
    w_amt         = 3'sd0;

    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (w_new_idx == IDX_ILL) begin
            w_state_nxt = StFault;
          end else if (w_new_idx != IDX_NONE) begin
            w_state_nxt   = StTrack;
            w_old_idx_nxt = w_new_idx;
          end
        end
      end
      StTrack: begin
        if (w_accept) begin
          if (w_new_idx == IDX_NONE) begin
            w_state_nxt = StIdle;
          end else if (w_new_idx == IDX_ILL) begin
            w_state_nxt = StFault;
          end else begin
            w_old_idx_nxt = w_new_idx;
            w_step_nxt    = 1'b1;
            case (w_delta)
              3'd1: begin w_amt = 3'sd1;  w_dir_nxt = 1'b1; w_half_nxt = 1'b1; end
              3'd2: begin w_amt = 3'sd2;  w_dir_nxt = 1'b1; w_half_nxt = 1'b0; end
              3'd5: begin w_amt = -3'sd1; w_dir_nxt = 1'b0; w_half_nxt = 1'b1; end
              3'd4: begin w_amt = -3'sd2; w_dir_nxt = 1'b0; w_half_nxt = 1'b0; end
              default: begin
                // Opposite side of the ring: direction is ambiguous
                w_state_nxt   = StFault;
                w_old_idx_nxt = r_old_idx;
                w_step_nxt    = 1'b0;
              end
            endcase
          end
        end
      end
      StFault: begin
        if (fault_clr) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    w_pos_nxt = r_pos + {{(POS_W-3){w_amt[2]}}, w_amt};
  end

  always_ff @(posedge clk) begin
    if (cr) begin
      r_state   <= StIdle;
      r_old_idx <= 3'd0;
      r_pos     <= '0;
      r_step    <= 1'b0;
      r_dir     <= 1'b1;
      r_half    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_old_idx <= w_old_idx_nxt;
      r_pos     <= w_pos_nxt;
      r_step    <= w_step_nxt;
      r_dir     <= w_dir_nxt;
      r_half    <= w_half_nxt;
    end
  end

  assign step     = r_step;
  assign dir      = r_dir;
  assign half     = r_half;
  assign pos      = r_pos;
  assign fault    = (r_state == StFault);
  assign tracking = (r_state == StTrack);

`ifdef STEP_STALL_DET_EN
  logic [19:0] r_idle_cnt;

  always_ff @(posedge clk) begin
    if (cr) begin
      r_idle_cnt <= 20'd0;
    end else if ((r_state == StTrack) && !r_step) begin
      if (r_idle_cnt != 20'hFFFFF) begin
        r_idle_cnt <= r_idle_cnt + 20'd1;
      end
    end else begin
      r_idle_cnt <= 20'd0;
    end
  end

  assign stall = (32'(r_idle_cnt) >= STALL_CYCLES);
`endif

endmodule
